vip_matrix_generate_nxn: RTL and testbench

VIP_MATRIX_GENERATE_NXN -- requirements
Module: vip_matrix_generate_nxn

---
 rtl/vip_pkg.sv | 20 ++
 rtl/vip_matrix_generate_nxn_if.sv | 34 +++
 rtl/vip_line_buffer.sv | 32 +++
 rtl/vip_matrix_generate_nxn.sv | 183 ++++++++++++++++++
 tb/tb_vip_matrix_generate_nxn.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/vip_pkg.sv
// Shared constants and helpers for the NxN window generator.
//   LAT         : strobe delay from input to matrix outputs
//   ksize_legal : elaboration-time check on the window size
//   win_idx     : bit offset of window element (r,c) inside matrix_data
package vip_pkg;

    localparam int unsigned LAT = 2;

    function automatic bit ksize_legal(input int unsigned k);
        return (k == 3) || (k == 5) || (k == 7);
    endfunction

    function automatic int unsigned win_idx(input int unsigned r,
                                            input int unsigned c,
                                            input int unsigned ksize,
                                            input int unsigned data_w);
        return (r * ksize + c) * data_w;
    endfunction

endpackage

// File: rtl/vip_matrix_generate_nxn_if.sv
// Pixel stream in / window stream out bundle.
//   per_frame_*     : input frame/line/pixel strobes, per_img_y pixel
//   matrix_frame_*  : strobes delayed to line up with the window
//   matrix_valid    : window fully populated with current-frame pixels
//   matrix_data     : KSIZE x KSIZE window, element (r,c) at (r*KSIZE+c)*DATA_W
//   line_overflow   : sticky, a line carried more than MAX_W pixels
// master = pixel source / window sink, slave = window generator.
interface vip_matrix_generate_nxn_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned KSIZE  = 5
);
    logic                            per_frame_vsync;
    logic                            per_frame_href;
    logic                            per_frame_clken;
    logic [DATA_W-1:0]               per_img_y;
    logic                            matrix_frame_vsync;
    logic                            matrix_frame_href;
    logic                            matrix_frame_clken;
    logic                            matrix_valid;
    logic [KSIZE*KSIZE*DATA_W-1:0]   matrix_data;
    logic                            line_overflow;

    modport master (
        output per_frame_vsync, per_frame_href, per_frame_clken, per_img_y,
        input  matrix_frame_vsync, matrix_frame_href, matrix_frame_clken,
        input  matrix_valid, matrix_data, line_overflow
    );

    modport slave (
        input  per_frame_vsync, per_frame_href, per_frame_clken, per_img_y,
        output matrix_frame_vsync, matrix_frame_href, matrix_frame_clken,
        output matrix_valid, matrix_data, line_overflow
    );
endinterface

// File: rtl/vip_line_buffer.sv
// One-line delay memory: simple dual port, synchronous write, registered read.
// Read-before-write at a shared address (the read returns the old word).
// Contents and read register are deliberately unreset so the array maps to block RAM.
//   clk              : clock
//   rd_en/rd_addr    : read request, rd_data valid one cycle later
//   wr_en/wr_addr    : write request with wr_data
module vip_line_buffer #(
    parameter  int unsigned DEPTH  = 1024,
    parameter  int unsigned DATA_W = 8,
    localparam int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

endmodule

// File: rtl/vip_matrix_generate_nxn.sv
// Sliding KSIZE x KSIZE window generator over a raster pixel stream.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of vip_matrix_generate_nxn_if (strobes + pixel in,
//                delayed strobes, window, valid and overflow flag out)
// Beat at cycle t: stage 1 (t+1) holds the line-buffer reads and the delayed
// current pixel, stage 2 (t+2) shifts the window and presents it.
module vip_matrix_generate_nxn
    import vip_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned KSIZE  = 5,
    parameter int unsigned MAX_W  = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    vip_matrix_generate_nxn_if.slave bus
);

    localparam int unsigned CW    = $clog2(MAX_W + 1);
    localparam int unsigned AW    = (MAX_W > 1) ? $clog2(MAX_W) : 1;
    localparam int unsigned RW    = $clog2(KSIZE);
    localparam int unsigned NBUF  = KSIZE - 1;
    localparam int unsigned WIN_W = KSIZE * KSIZE * DATA_W;

    if (!ksize_legal(KSIZE)) begin : g_ksize_check
        $error("vip_matrix_generate_nxn: KSIZE must be 3, 5 or 7");
    end

    logic [LAT-1:0]    vs_pipe;
    logic [LAT-1:0]    href_pipe;
    logic [LAT-1:0]    clken_pipe;
    logic [CW-1:0]     col_cnt;
    logic [RW-1:0]     row_cnt;
    logic              frame_armed;
    logic              overflow_q;
    logic              accept_d1;
    logic [CW-1:0]     col_d1;
    logic [RW-1:0]     row_d1;
    logic [DATA_W-1:0] pix_d1;
    logic [WIN_W-1:0]  win_q;
    logic [WIN_W-1:0]  win_shift_c;
    logic              valid_q;
    logic [DATA_W-1:0] rd_data [NBUF];

    logic vsync_rise_c;
    logic href_fall_c;
    logic accept_c;
    logic drop_c;

    // Edge detects use the first strobe-pipe stage as the previous-cycle sample.
    assign vsync_rise_c = bus.per_frame_vsync & ~vs_pipe[0];
    assign href_fall_c  = href_pipe[0] & ~bus.per_frame_href;
    assign accept_c     = bus.per_frame_clken & (col_cnt < CW'(MAX_W));
    assign drop_c       = bus.per_frame_clken & (col_cnt == CW'(MAX_W));

    // Strobe delay pipes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_pipe    <= '0;
            href_pipe  <= '0;
            clken_pipe <= '0;
        end else begin
            vs_pipe    <= {vs_pipe[LAT-2:0],    bus.per_frame_vsync};
            href_pipe  <= {href_pipe[LAT-2:0],  bus.per_frame_href};
            clken_pipe <= {clken_pipe[LAT-2:0], bus.per_frame_clken};
        end
    end

    // Column/row position; a beat on the href falling edge still uses the old column.
    // Rows only count once a vsync rise has been seen, so a mid-frame reset
    // cannot produce windows built from a partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt     <= '0;
            row_cnt     <= '0;
            frame_armed <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            if (href_fall_c) begin
                col_cnt <= '0;
            end else if (accept_c) begin
                col_cnt <= col_cnt + CW'(1);
            end

            if (vsync_rise_c) begin
                row_cnt <= '0;
            end else if (href_fall_c && frame_armed && (row_cnt != RW'(KSIZE - 1))) begin
                row_cnt <= row_cnt + RW'(1);
            end

            if (vsync_rise_c) begin
                frame_armed <= 1'b1;
            end

            // Set wins over the vsync clear.
            if (drop_c) begin
                overflow_q <= 1'b1;
            end else if (vsync_rise_c) begin
                overflow_q <= 1'b0;
            end
        end
    end

    // Stage 1: beat bookkeeping and current pixel, aligned with line-buffer reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            accept_d1 <= 1'b0;
            col_d1    <= '0;
            row_d1    <= '0;
            pix_d1    <= '0;
        end else begin
            accept_d1 <= accept_c;
            col_d1    <= col_cnt;
            row_d1    <= row_cnt;
            if (accept_c) begin
                pix_d1 <= bus.per_img_y;
            end
        end
    end

    // Cascaded line buffers: read at the beat, write one cycle later at the same
    // column so buffer k can be fed from buffer k-1's read data.
    for (genvar k = 0; k < NBUF; k++) begin : g_lb
        logic [DATA_W-1:0] wr_data;

        if (k == 0) begin : g_head
            assign wr_data = pix_d1;
        end else begin : g_tail
            assign wr_data = rd_data[k-1];
        end

        vip_line_buffer #(
            .DEPTH  (MAX_W),
            .DATA_W (DATA_W)
        ) u_line_buffer (
            .clk     (clk),
            .rd_en   (accept_c),
            .rd_addr (AW'(col_cnt)),
            .rd_data (rd_data[k]),
            .wr_en   (accept_d1),
            .wr_addr (AW'(col_d1)),
            .wr_data (wr_data)
        );
    end

    // Window shifted left by one column with the new column on the right.
    for (genvar r = 0; r < KSIZE; r++) begin : g_row
        for (genvar c = 0; c < KSIZE; c++) begin : g_col
            if (c < KSIZE - 1) begin : g_shift
                assign win_shift_c[win_idx(r, c, KSIZE, DATA_W) +: DATA_W] =
                    win_q[win_idx(r, c + 1, KSIZE, DATA_W) +: DATA_W];
            end else if (r < KSIZE - 1) begin : g_buf
                assign win_shift_c[win_idx(r, c, KSIZE, DATA_W) +: DATA_W] =
                    rd_data[KSIZE - 2 - r];
            end else begin : g_cur
                assign win_shift_c[win_idx(r, c, KSIZE, DATA_W) +: DATA_W] = pix_d1;
            end
        end
    end

    // Stage 2: window register and validity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            if (accept_d1) begin
                win_q <= win_shift_c;
            end
            valid_q <= clken_pipe[0] & accept_d1
                     & (col_d1 >= CW'(KSIZE - 1))
                     & (row_d1 == RW'(KSIZE - 1));
        end
    end

    assign bus.matrix_frame_vsync = vs_pipe[LAT-1];
    assign bus.matrix_frame_href  = href_pipe[LAT-1];
    assign bus.matrix_frame_clken = clken_pipe[LAT-1];
    assign bus.matrix_valid       = valid_q;
    assign bus.matrix_data        = win_q;
    assign bus.line_overflow      = overflow_q;

endmodule

// File: tb/tb_vip_matrix_generate_nxn.sv
// Bench for vip_matrix_generate_nxn: a 3x3/MAX_W=8 instance and a default 5x5
// instance, driven with ramp and random frames, random clken gaps, overflow
// lines and a mid-frame reset. Expected windows come from a stored image.
module tb_vip_matrix_generate_nxn;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    vip_matrix_generate_nxn_if #(.DATA_W(8), .KSIZE(3)) if3 ();
    vip_matrix_generate_nxn_if #(.DATA_W(8), .KSIZE(5)) if5 ();

    vip_matrix_generate_nxn #(.DATA_W(8), .KSIZE(3), .MAX_W(8)) u_dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if3.slave)
    );

    vip_matrix_generate_nxn #(.DATA_W(8), .KSIZE(5), .MAX_W(1024)) u_dut5 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if5.slave)
    );

    logic [1:0] vs, hr, ce;
    logic [7:0] py [2];

    assign if3.per_frame_vsync = vs[0];
    assign if3.per_frame_href  = hr[0];
    assign if3.per_frame_clken = ce[0];
    assign if3.per_img_y       = py[0];
    assign if5.per_frame_vsync = vs[1];
    assign if5.per_frame_href  = hr[1];
    assign if5.per_frame_clken = ce[1];
    assign if5.per_img_y       = py[1];

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: the frame as sent, plus the windows it must produce in order.
    logic [7:0]   img [0:1][0:15][0:15];
    bit           armed [2];
    logic [255:0] exp_q0 [$];
    logic [255:0] exp_q1 [$];
    logic [255:0] obs0 [$];
    logic [255:0] ref_log [$];
    int           vcnt [2];
    logic [255:0] e0, e1;

    function automatic int ksz(input int d);
        return (d == 1) ? 5 : 3;
    endfunction

    function automatic int maxw(input int d);
        return (d == 1) ? 1024 : 8;
    endfunction

    function automatic logic [255:0] model_window(input int d, input int row, input int col);
        int k = ksz(d);
        logic [255:0] w = '0;
        for (int r = 0; r < k; r++)
            for (int c = 0; c < k; c++)
                w[(r * k + c) * 8 +: 8] = img[d][row - k + 1 + r][col - k + 1 + c];
        return w;
    endfunction

    task automatic expect_beat(input int d, input int row, input int col);
        if (armed[d] && row >= ksz(d) - 1 && col >= ksz(d) - 1 && col < maxw(d)) begin
            if (d == 0) exp_q0.push_back(model_window(d, row, col));
            else        exp_q1.push_back(model_window(d, row, col));
        end
    endtask

    // Window monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (if3.matrix_valid) begin
                vcnt[0]++;
                obs0.push_back(256'(if3.matrix_data));
                if (exp_q0.size() == 0) check_eq("win3_unexpected_valid", 1, 0);
                else begin
                    e0 = exp_q0.pop_front();
                    check_eq("win3", 256'(if3.matrix_data), e0);
                end
            end
            if (if5.matrix_valid) begin
                vcnt[1]++;
                if (exp_q1.size() == 0) check_eq("win5_unexpected_valid", 1, 0);
                else begin
                    e1 = exp_q1.pop_front();
                    check_eq("win5", 256'(if5.matrix_data), e1);
                end
            end
        end
    end

    task automatic drive(input int d, input logic v, input logic h, input logic c, input logic [7:0] y);
        vs[d] = v;
        hr[d] = h;
        ce[d] = c;
        py[d] = y;
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_strobes3"}, {if3.matrix_frame_vsync, if3.matrix_frame_href,
                  if3.matrix_frame_clken, if3.matrix_valid, if3.line_overflow}, 0);
        check_eq({tag, "_data3"}, 256'(if3.matrix_data), 0);
        check_eq({tag, "_strobes5"}, {if5.matrix_frame_vsync, if5.matrix_frame_href,
                  if5.matrix_frame_clken, if5.matrix_valid, if5.line_overflow}, 0);
        check_eq({tag, "_data5"}, 256'(if5.matrix_data), 0);
    endtask

    // Mid-frame reset: in-flight windows are lost and the frame is no longer armed.
    task automatic do_reset(input int d);
        rst_n = 1'b0;
        exp_q0.delete();
        exp_q1.delete();
        armed[0] = 1'b0;
        armed[1] = 1'b0;
        vcnt[0] = 0;
        vcnt[1] = 0;
        for (int i = 0; i < 3; i++) begin
            drive(d, 1'b0, 1'b1, 1'b0, 8'(i));
            check_outputs_zero("mid_reset");
        end
        rst_n = 1'b1;
    endtask

    task automatic send_frame(input int d, input int w, input int h, input int gap,
                              input bit rnd, input bit late, input int rst_row,
                              output int nvalid);
        logic [7:0] pix;
        int g;
        vcnt[d] = 0;
        if (d == 0) obs0.delete();
        for (int i = 0; i < 3; i++) begin
            if (i == 0) armed[d] = 1'b1;
            drive(d, 1'b1, 1'b0, 1'b0, 8'h00);
        end
        repeat (2) drive(d, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int row = 0; row < h; row++) begin
            for (int col = 0; col < w; col++) begin
                if (row == rst_row && col == 3) do_reset(d);
                g = (gap > 0) ? int'($urandom_range(gap, 0)) : 0;
                repeat (g) drive(d, 1'b0, 1'b1, 1'b0, 8'($urandom));
                pix = rnd ? 8'($urandom) : 8'(row * 16 + col);
                img[d][row][col] = pix;
                expect_beat(d, row, col);
                drive(d, 1'b0, !(late && col == w - 1), 1'b1, pix);
            end
            repeat (2) drive(d, 1'b0, 1'b0, 1'b0, 8'h00);
        end
        repeat (4) drive(d, 1'b0, 1'b0, 1'b0, 8'h00);
        nvalid = vcnt[d];
    endtask

    logic [255:0] first_win;
    int n;

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vs = '0; hr = '0; ce = '0; py[0] = '0; py[1] = '0;
        rst_n = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check_outputs_zero("reset");
        rst_n = 1'b1;
        repeat (2) drive(0, 1'b0, 1'b0, 1'b0, 8'h00);

        // Single beat: strobes and pixel appear exactly two cycles later.
        armed[0] = 1'b1;
        drive(0, 1'b1, 1'b1, 1'b1, 8'h5A);
        check_eq("lat_t1", {if3.matrix_frame_vsync, if3.matrix_frame_href, if3.matrix_frame_clken}, 3'b000);
        drive(0, 1'b0, 1'b0, 1'b0, 8'h00);
        check_eq("lat_t2", {if3.matrix_frame_vsync, if3.matrix_frame_href, if3.matrix_frame_clken}, 3'b111);
        check_eq("lat_pix", if3.matrix_data[64 +: 8], 8'h5A);
        drive(0, 1'b0, 1'b0, 1'b0, 8'h00);
        check_eq("lat_t3", {if3.matrix_frame_vsync, if3.matrix_frame_href, if3.matrix_frame_clken}, 3'b000);
        repeat (2) drive(0, 1'b0, 1'b0, 1'b0, 8'h00);

        // 6 columns x 6 lines ramp: 4x4 = 16 full 3x3 windows per frame.
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                first_win[(r * 3 + c) * 8 +: 8] = 8'(r * 16 + c);
        first_win[255:72] = '0;
        send_frame(0, 6, 6, 0, 1'b0, 1'b0, -1, n);
        check_eq("cnt3_contig", n, 16);
        ref_log = obs0;
        if (ref_log.size() > 0) check_eq("first_win3", ref_log[0], first_win);
        else check_eq("first_win3_missing", 0, 1);

        // Same image with random clken gaps must give the identical window sequence.
        send_frame(0, 6, 6, 3, 1'b0, 1'b0, -1, n);
        check_eq("cnt3_gaps", n, 16);
        check_eq("gap_seq_len", obs0.size(), ref_log.size());
        for (int i = 0; i < obs0.size() && i < ref_log.size(); i++)
            check_eq("gap_seq_win", obs0[i], ref_log[i]);

        // Random pixels, gaps, and a beat on the href falling edge.
        send_frame(0, 6, 6, 2, 1'b1, 1'b1, -1, n);
        check_eq("cnt3_rand_late", n, 16);

        // Overflow: lines 0,1 of 8 pixels, line 2 of 10 pixels.
        armed[0] = 1'b1;
        drive(0, 1'b1, 1'b0, 1'b0, 8'h00);
        repeat (2) drive(0, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int row = 0; row < 3; row++) begin
            for (int col = 0; col < ((row == 2) ? 10 : 8); col++) begin
                img[0][row][col] = 8'($urandom);
                expect_beat(0, row, col);
                drive(0, 1'b0, 1'b1, 1'b1, img[0][row][col]);
                check_eq("ovf_flag", if3.line_overflow, (row == 2 && col >= 8));
            end
            if (row < 2) repeat (2) drive(0, 1'b0, 1'b0, 1'b0, 8'h00);
        end
        repeat (2) drive(0, 1'b0, 1'b1, 1'b0, 8'h00);
        check_eq("ovf_win_row2", if3.matrix_data[48 +: 24], {img[0][2][7], img[0][2][6], img[0][2][5]});
        drive(0, 1'b1, 1'b1, 1'b1, 8'hEE);
        check_eq("ovf_set_wins", if3.line_overflow, 1);
        repeat (3) drive(0, 1'b0, 1'b0, 1'b0, 8'h00);
        check_eq("ovf_hold", if3.line_overflow, 1);
        drive(0, 1'b1, 1'b0, 1'b0, 8'h00);
        check_eq("ovf_clear", if3.line_overflow, 0);
        repeat (3) drive(0, 1'b0, 1'b0, 1'b0, 8'h00);

        // Reset in the middle of line 3, then a clean frame.
        send_frame(0, 6, 6, 0, 1'b0, 1'b0, 3, n);
        check_eq("rst_no_valid", n, 0);
        send_frame(0, 6, 6, 1, 1'b0, 1'b0, -1, n);
        check_eq("cnt3_after_rst", n, 16);
        if (obs0.size() > 0) check_eq("first_win3_after_rst", obs0[0], first_win);
        else check_eq("first_win3_after_rst_missing", 0, 1);

        // 5x5 on a 16x8 image: 12 x 4 = 48 windows per frame.
        send_frame(1, 16, 8, 0, 1'b0, 1'b0, -1, n);
        check_eq("cnt5_ramp", n, 48);
        send_frame(1, 16, 8, 3, 1'b1, 1'b0, -1, n);
        check_eq("cnt5_rand_gaps", n, 48);
        send_frame(1, 16, 8, 2, 1'b1, 1'b1, -1, n);
        check_eq("cnt5_rand_late", n, 48);

        repeat (4) drive(0, 1'b0, 1'b0, 1'b0, 8'h00);
        check_eq("pending3", exp_q0.size(), 0);
        check_eq("pending5", exp_q1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
